memory_scan_display: RTL

Parametrised successor to the fixed address-walker plus 7-segment path: one block sequences addresses through a memory controller via a request/ready handshake and holds the last word read. It multiplexes that word onto DIGIT_COUNT hex digits. Step and refresh rates come from internal clock-enable counters on a single clock, replacing the cascaded divided clocks. Sits between memory_control and hex_cathode; adds run/once/single-step/hold modes and a programmable address window.

---
 rtl/memory_scan_display_pkg.sv | 17 +
 rtl/memory_scan_display_if.sv | 26 ++
 rtl/memory_scan_display_display_multiplexer.sv | 46 ++++
 rtl/memory_scan_display.sv | 131 +++++++++++++
 4 files changed

// File: rtl/memory_scan_display_pkg.sv
// Shared types and constants for the memory scan / hex display slice.
package memory_scan_display_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StRequest,
        StWait
    } scan_state_e;

    localparam logic [1:0] MODE_HOLD        = 2'b00;
    localparam logic [1:0] MODE_RUN_WRAP    = 2'b01;
    localparam logic [1:0] MODE_RUN_ONCE    = 2'b10;
    localparam logic [1:0] MODE_SINGLE_STEP = 2'b11;

    localparam int unsigned NIBBLE_WIDTH = 4;

endpackage

// File: rtl/memory_scan_display_if.sv
// Read request/ready handshake between the scanner and the memory controller.
interface memory_scan_display_if #(
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned DATA_WIDTH    = 16
);

    logic                     request;
    logic [ADDRESS_WIDTH-1:0] request_address;
    logic                     ready;
    logic [DATA_WIDTH-1:0]    read_data;

    modport master (
        output request,
        output request_address,
        input  ready,
        input  read_data
    );

    modport slave (
        input  request,
        input  request_address,
        output ready,
        output read_data
    );

endinterface

// File: rtl/memory_scan_display_display_multiplexer.sv
// Time-multiplexes a captured word onto DIGIT_COUNT active-low hex digit selects.
module display_multiplexer
    import memory_scan_display_pkg::*;
#(
    parameter int unsigned DIGIT_COUNT      = 4,
    parameter int unsigned REFRESH_DIVISION = 100000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NIBBLE_WIDTH*DIGIT_COUNT-1:0] buffer,
    output logic [DIGIT_COUNT-1:0]            anode,
    output logic [NIBBLE_WIDTH-1:0]           digit
);

    localparam int unsigned RefreshWidth = $clog2(REFRESH_DIVISION);
    localparam int unsigned IndexWidth   = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
    localparam logic [RefreshWidth-1:0] RefreshLast = RefreshWidth'(REFRESH_DIVISION - 1);
    localparam logic [IndexWidth-1:0]   IndexLast   = IndexWidth'(DIGIT_COUNT - 1);

    logic [RefreshWidth-1:0] refresh_count_q;
    logic [IndexWidth-1:0]   index_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_count_q <= '0;
            index_q         <= '0;
        end else if (refresh_count_q == RefreshLast) begin
            refresh_count_q <= '0;
            index_q         <= (index_q == IndexLast) ? '0 : index_q + 1'b1;
        end else begin
            refresh_count_q <= refresh_count_q + 1'b1;
        end
    end

    always_comb begin
        anode = '1;
        digit = '0;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            if (index_q == IndexWidth'(i)) begin
                anode[i] = 1'b0;
                digit    = buffer[i*NIBBLE_WIDTH +: NIBBLE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/memory_scan_display.sv
// Walks an address window through the memory controller and shows the last word on hex digits.
module memory_scan_display
    import memory_scan_display_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH    = 10,
    parameter int unsigned DIGIT_COUNT      = 4,
    parameter int unsigned STEP_DIVISION    = 25000000,
    parameter int unsigned REFRESH_DIVISION = 100000
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [1:0]                          mode,
    input  logic                                step,
    input  logic                                reload,
    input  logic [ADDRESS_WIDTH-1:0]            start_address,
    input  logic [ADDRESS_WIDTH-1:0]            end_address,
    memory_scan_display_if.master               memory,
    output logic [NIBBLE_WIDTH*DIGIT_COUNT-1:0] buffer,
    output logic                                done,
    output logic [DIGIT_COUNT-1:0]              anode,
    output logic [NIBBLE_WIDTH-1:0]             digit
);

    localparam int unsigned DataWidth = NIBBLE_WIDTH * DIGIT_COUNT;
    localparam int unsigned StepWidth = $clog2(STEP_DIVISION);
    localparam logic [StepWidth-1:0] StepLast = StepWidth'(STEP_DIVISION - 1);

    scan_state_e              state_q;
    logic                     request_q;
    logic [ADDRESS_WIDTH-1:0] request_address_q;
    logic [DataWidth-1:0]     buffer_q;
    logic                     done_q;

    logic [StepWidth-1:0]     step_count_q;
    logic [1:0]               mode_q;
    logic                     mode_changed;
    logic                     step_tick;
    logic                     trigger;

    // The step counter restarts on every mode change so the first automatic
    // step after switching modes is always a full period away.
    assign mode_changed = (mode != mode_q);
    assign step_tick    = (step_count_q == StepLast) && !mode_changed;

    always_ff @(posedge clock) begin
        mode_q <= mode;
        if (reset || mode_changed || step_count_q == StepLast) begin
            step_count_q <= '0;
        end else begin
            step_count_q <= step_count_q + 1'b1;
        end
    end

    always_comb begin
        trigger = 1'b0;
        unique case (mode)
            MODE_HOLD:        trigger = 1'b0;
            MODE_RUN_WRAP:    trigger = step_tick;
            MODE_RUN_ONCE:    trigger = step_tick;
            MODE_SINGLE_STEP: trigger = step;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= StLoad;
            request_q         <= 1'b0;
            request_address_q <= '0;
            buffer_q          <= '0;
            done_q            <= 1'b0;
        end else if (reload) begin
            // Any open request is abandoned; a late ready lands outside StRequest.
            state_q   <= StLoad;
            request_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (mode != MODE_RUN_ONCE) begin
                done_q <= 1'b0;
            end
            unique case (state_q)
                StLoad: begin
                    request_address_q <= start_address;
                    done_q            <= 1'b0;
                    request_q         <= 1'b1;
                    state_q           <= StRequest;
                end
                StRequest: begin
                    if (memory.ready) begin
                        buffer_q  <= memory.read_data;
                        request_q <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (trigger && !done_q) begin
                        if (request_address_q == end_address && mode == MODE_RUN_ONCE) begin
                            done_q <= 1'b1;
                        end else begin
                            request_address_q <= (request_address_q == end_address)
                                               ? start_address
                                               : request_address_q + 1'b1;
                            request_q         <= 1'b1;
                            state_q           <= StRequest;
                        end
                    end
                end
                default: begin
                    request_q <= 1'b0;
                    state_q   <= StLoad;
                end
            endcase
        end
    end

    assign memory.request         = request_q;
    assign memory.request_address = request_address_q;
    assign buffer                 = buffer_q;
    assign done                   = done_q;

    display_multiplexer #(
        .DIGIT_COUNT      (DIGIT_COUNT),
        .REFRESH_DIVISION (REFRESH_DIVISION)
    ) u_display_multiplexer (
        .clock  (clock),
        .reset  (reset),
        .buffer (buffer_q),
        .anode  (anode),
        .digit  (digit)
    );

endmodule
